child_inst_arbiter: RTL and testbench

Round-robin arbiter that shares one resource slot among the five child instances (inst_0..inst_4) of a hierarchy node. Each child raises a request. The arbiter grants exactly one child at a time and holds the grant until that child releases it. An optional hold-timeout reclaims the grant from a stuck owner. One arbiter sits at each parent level, between the child instances and the shared resource.

---
 rtl/child_inst_arbiter.sv | 112 +++++++++++
 tb/tb_child_inst_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/child_inst_arbiter.sv
// child_inst_arbiter: round-robin arbiter sharing one resource slot among
// N_REQ child instances. A grant is held until the owner releases it (done
// or dropped request). Optional hold-timeout reclaims the slot from a stuck
// owner; it is built only when CHILD_ARB_TIMEOUT_EN is defined.
module child_inst_arbiter #(
    parameter int N_REQ    = 5,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
    output logic [N_REQ-1:0]  gnt,
    output logic [ID_W-1:0]   gnt_id,
    output logic              busy,
    output logic              timeout_err
);

    // Reject configurations outside the supported range at elaboration.
    generate
        if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
            $error("child_inst_arbiter: N_REQ or MAX_HOLD out of range");
        end
    endgenerate

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic             found;
    logic             own_release;
    logic             hold_expire;
    logic [ID_W-1:0]  ptr_next;

    // Pick the first requester at or above ptr, wrapping past N_REQ-1.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Owner releases by strobing done or by dropping its request.
    assign own_release = done[gnt_id] | ~req[gnt_id];

    // Next pointer: one past the leaving owner, modulo N_REQ.
    assign ptr_next = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

`ifdef CHILD_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt;

    // Expiry fires in the MAX_HOLD-th grant cycle (counter starts at 0).
    assign hold_expire = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    assign hold_expire = 1'b0;
`endif

    // Arbiter FSM; every output is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt         <= '0;
            gnt_id      <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
`ifdef CHILD_ARB_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    timeout_err <= 1'b0;
                    if (found) begin
                        state  <= GRANT;
                        gnt    <= N_REQ'(1) << win;
                        gnt_id <= win;
                        busy   <= 1'b1;
`ifdef CHILD_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
`ifdef CHILD_ARB_TIMEOUT_EN
                    if (hold_cnt != HOLD_W'(MAX_HOLD))
                        hold_cnt <= hold_cnt + 1'b1;
`endif
                    // A release in the expiry cycle wins over the timeout.
                    if (own_release || hold_expire) begin
                        state       <= IDLE;
                        gnt         <= '0;
                        busy        <= 1'b0;
                        ptr         <= ptr_next;
                        timeout_err <= ~own_release;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_child_inst_arbiter.sv
// Testbench for child_inst_arbiter: table-driven cycle vectors with a
// scoreboard queue, plus hand sequences for contention, timeout and reset.
module tb_child_inst_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout_err;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [4:0] req;
        logic [4:0] done;
        logic [4:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       terr;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[22];

    child_inst_arbiter #(.N_REQ(5), .MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [4:0] r, input logic [4:0] d,
                                input logic [4:0] g, input logic [2:0] id,
                                input logic b, input logic t);
        vec_t v;
        v.req = r; v.done = d; v.gnt = g; v.id = id; v.busy = b; v.terr = t;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string nm);
        vec_t e;
        req  = v.req;
        done = v.done;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({nm, ".queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({nm, ".gnt"},    int'(gnt),         int'(e.gnt));
            chk({nm, ".gnt_id"}, int'(gnt_id),      int'(e.id));
            chk({nm, ".busy"},   int'(busy),        int'(e.busy));
            chk({nm, ".terr"},   int'(timeout_err), int'(e.terr));
            chk({nm, ".onehot"}, int'($onehot0(gnt)), 1);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        @(posedge clk);
        #1;
        chk("reset.gnt",    int'(gnt), 0);
        chk("reset.gnt_id", int'(gnt_id), 0);
        chk("reset.busy",   int'(busy), 0);
        chk("reset.terr",   int'(timeout_err), 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; done = '0;

        // Directed cycle table starting from ptr=0.
        tbl[0]  = mk(5'b00100, 5'b00000, 5'b00100, 3'd2, 1, 0);
        tbl[1]  = mk(5'b00100, 5'b00000, 5'b00100, 3'd2, 1, 0);
        tbl[2]  = mk(5'b00100, 5'b00000, 5'b00100, 3'd2, 1, 0);
        tbl[3]  = mk(5'b00100, 5'b00100, 5'b00000, 3'd2, 0, 0);
        tbl[4]  = mk(5'b11111, 5'b00000, 5'b01000, 3'd3, 1, 0);
        tbl[5]  = mk(5'b11111, 5'b01000, 5'b00000, 3'd3, 0, 0);
        tbl[6]  = mk(5'b01010, 5'b00000, 5'b00010, 3'd1, 1, 0);
        tbl[7]  = mk(5'b01010, 5'b00010, 5'b00000, 3'd1, 0, 0);
        tbl[8]  = mk(5'b01010, 5'b00000, 5'b01000, 3'd3, 1, 0);
        tbl[9]  = mk(5'b01010, 5'b01000, 5'b00000, 3'd3, 0, 0);
        tbl[10] = mk(5'b11111, 5'b00000, 5'b10000, 3'd4, 1, 0);
        tbl[11] = mk(5'b11111, 5'b10000, 5'b00000, 3'd4, 0, 0);
        tbl[12] = mk(5'b11111, 5'b00000, 5'b00001, 3'd0, 1, 0);
        tbl[13] = mk(5'b11111, 5'b01000, 5'b00001, 3'd0, 1, 0);
        tbl[14] = mk(5'b11111, 5'b00001, 5'b00000, 3'd0, 0, 0);
        tbl[15] = mk(5'b11111, 5'b00000, 5'b00010, 3'd1, 1, 0);
        tbl[16] = mk(5'b11101, 5'b00000, 5'b00000, 3'd1, 0, 0);
        tbl[17] = mk(5'b00000, 5'b11111, 5'b00000, 3'd1, 0, 0);
        tbl[18] = mk(5'b00000, 5'b00000, 5'b00000, 3'd1, 0, 0);
        tbl[19] = mk(5'b00001, 5'b00000, 5'b00001, 3'd0, 1, 0);
        tbl[20] = mk(5'b00001, 5'b00000, 5'b00001, 3'd0, 1, 0);
        tbl[21] = mk(5'b00000, 5'b00000, 5'b00000, 3'd0, 0, 0);

        #2;
        do_reset();
        for (int i = 0; i < 22; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Full contention from reset: order 0,1,2,3,4,0 with one IDLE gap each.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            logic [2:0] id;
            logic [4:0] oh;
            id = 3'(k % 5);
            oh = 5'b00001 << id;
            step(mk(5'b11111, 5'b00000, oh, id, 1, 0), $sformatf("rr%0d.grant", k));
            step(mk(5'b11111, oh, 5'b00000, id, 0, 0), $sformatf("rr%0d.idle", k));
        end

`ifdef CHILD_ARB_TIMEOUT_EN
        // Stuck owner 0: exactly 16 grant cycles, then one timeout pulse, then 1.
        do_reset();
        for (int i = 0; i < 16; i++)
            step(mk(5'b00011, 5'b00000, 5'b00001, 3'd0, 1, 0), $sformatf("to.hold%0d", i));
        step(mk(5'b00011, 5'b00000, 5'b00000, 3'd0, 0, 1), "to.expire");
        step(mk(5'b00011, 5'b00000, 5'b00010, 3'd1, 1, 0), "to.next");
        step(mk(5'b00011, 5'b00010, 5'b00000, 3'd1, 0, 0), "to.rel");

        // done in the expiry cycle counts as a release: no timeout pulse.
        do_reset();
        for (int i = 0; i < 16; i++)
            step(mk(5'b00001, 5'b00000, 5'b00001, 3'd0, 1, 0), $sformatf("col.hold%0d", i));
        step(mk(5'b00001, 5'b00001, 5'b00000, 3'd0, 0, 0), "col.release");
        step(mk(5'b00000, 5'b00000, 5'b00000, 3'd0, 0, 0), "col.quiet");
`else
        // Without the timeout a grant is held well past MAX_HOLD.
        do_reset();
        for (int i = 0; i < 24; i++)
            step(mk(5'b00011, 5'b00000, 5'b00001, 3'd0, 1, 0), $sformatf("nto.hold%0d", i));
        step(mk(5'b00011, 5'b00001, 5'b00000, 3'd0, 0, 0), "nto.rel");
        step(mk(5'b00011, 5'b00000, 5'b00010, 3'd1, 1, 0), "nto.next");
`endif

        // Async reset between edges while 2 owns the grant.
        do_reset();
        step(mk(5'b00100, 5'b00000, 5'b00100, 3'd2, 1, 0), "ar.grant");
        #2;
        rst = 1'b1;
        #1;
        chk("ar.gnt_async",  int'(gnt), 0);
        chk("ar.busy_async", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(mk(5'b11111, 5'b00000, 5'b00001, 3'd0, 1, 0), "ar.first");
        step(mk(5'b11111, 5'b00001, 5'b00000, 3'd0, 0, 0), "ar.rel");

        chk("scoreboard.drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
